// File: rtl/cache_fill_ctrl_pkg.sv
// Shared definitions for the cache fill controller: FSM states, block geometry
// and cache-select encodings.
package cache_fill_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam int unsigned BLOCK_WORDS = 8;
  localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/cache_fill_ctrl_counter.sv
// 4-bit word counter with synchronous clear and increment; used for both the
// issue and the return side of a block fill.
module fill_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Block-fill / write-through controller shared by the I- and D-caches.
// Arbitrates store > D-miss > I-miss, streams reads and writes returned words.
module cache_fill_ctrl #(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned BLOCK_WORDS = cache_fill_ctrl_pkg::BLOCK_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imiss,
  input  logic [15:0] imiss_addr,
  input  logic        dmiss,
  input  logic [15:0] dmiss_addr,
  input  logic        dstore,
  input  logic [15:0] dstore_addr,
  input  logic [15:0] dstore_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        fill_we,
  output logic        fill_sel,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        tag_we,
  output logic [15:0] fill_base,
  output logic        idone,
  output logic        ddone,
  output logic        busy
);

  import cache_fill_ctrl_pkg::*;

  localparam logic [3:0] LAST = 4'(BLOCK_WORDS - 1);

  if (MEM_LATENCY == 0) begin : g_bad_latency
    $error("MEM_LATENCY must be at least 1");
  end

  state_t      state;
  logic        sel;
  logic [15:0] base;
  logic [3:0]  issue_cnt;
  logic [3:0]  ret_cnt;
  logic        active;
  logic [15:0] miss_base;

  assign active    = (state == ISSUE) || (state == WAIT);
  assign miss_base = (dmiss ? dmiss_addr : imiss_addr) & BLOCK_MASK;

  // Return path is combinational so a word lands in the array the cycle it arrives.
  assign fill_we   = mem_rvalid && active;
  assign fill_sel  = sel;
  assign fill_word = ret_cnt[2:0];
  assign fill_data = fill_we ? mem_rdata : '0;
  assign fill_base = base;

  fill_counter u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == IDLE),
    .inc   (state == ISSUE),
    .count (issue_cnt)
  );

  fill_counter u_ret_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == IDLE),
    .inc   (fill_we),
    .count (ret_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= SEL_I;
      base      <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tag_we    <= 1'b0;
      idone     <= 1'b0;
      ddone     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      tag_we <= 1'b0;
      idone  <= 1'b0;
      ddone  <= 1'b0;
      case (state)
        IDLE: begin
          if (dstore) begin
            state     <= STORE;
            sel       <= SEL_D;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= dstore_addr;
            mem_wdata <= dstore_data;
            ddone     <= 1'b1;
            busy      <= 1'b1;
          end else if (dmiss || imiss) begin
            state    <= ISSUE;
            sel      <= dmiss ? SEL_D : SEL_I;
            base     <= miss_base;
            mem_en   <= 1'b1;
            mem_wr   <= 1'b0;
            mem_addr <= miss_base;
            busy     <= 1'b1;
          end
        end
        STORE: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          busy   <= 1'b0;
        end
        ISSUE, WAIT: begin
          if (state == ISSUE) begin
            if (issue_cnt == LAST) begin
              state  <= WAIT;
              mem_en <= 1'b0;
            end else begin
              mem_addr <= base + {11'b0, issue_cnt + 4'd1, 1'b0};
            end
          end
          // Last return overrides the issue-side transition.
          if (mem_rvalid && ret_cnt == LAST) begin
            state  <= DONE;
            mem_en <= 1'b0;
            tag_we <= 1'b1;
            idone  <= (sel == SEL_I);
            ddone  <= (sel == SEL_D);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: latency memory model, event
// scoreboard with cycle stamps, vector table plus directed corner sequences.
module tb_cache_fill_ctrl;
  import cache_fill_ctrl_pkg::*;

  localparam int LAT = 4;

  logic        clk = 0, rst = 1;
  logic        imiss = 0, dmiss = 0, dstore = 0, mem_rvalid = 0;
  logic [15:0] imiss_addr = '0, dmiss_addr = '0, dstore_addr = '0, dstore_data = '0;
  logic [15:0] mem_rdata = '0;
  logic        mem_en, mem_wr, fill_we, fill_sel, tag_we, idone, ddone, busy;
  logic [15:0] mem_addr, mem_wdata, fill_data, fill_base;
  logic [2:0]  fill_word;

  cache_fill_ctrl #(.MEM_LATENCY(LAT), .BLOCK_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .imiss(imiss), .imiss_addr(imiss_addr),
    .dmiss(dmiss), .dmiss_addr(dmiss_addr),
    .dstore(dstore), .dstore_addr(dstore_addr), .dstore_data(dstore_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_sel(fill_sel), .fill_word(fill_word), .fill_data(fill_data),
    .tag_we(tag_we), .fill_base(fill_base), .idone(idone), .ddone(ddone), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0, n_fail = 0;
  logic mon_on = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic [2:0]  word;
    logic        sel;
    logic        tag;
    int          cyc;
  } ev_t;

  ev_t rd_q[$], wr_q[$], fill_q[$], done_q[$];

  // Memory model: a read accepted in cycle j returns addr^5A5A in cycle j+LAT.
  logic [LAT-1:0] pipe_v = '0;
  logic [15:0]    pipe_a [LAT];
  logic           stray_v = 0;
  logic [15:0]    stray_d = '0;

  always @(negedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0] = mem_en && !mem_wr;
    pipe_a[0] = mem_addr;
  end

  always @(posedge clk) begin
    #2;
    mem_rvalid = pipe_v[LAT-1] | stray_v;
    mem_rdata  = stray_v ? stray_d : (pipe_v[LAT-1] ? (pipe_a[LAT-1] ^ 16'h5A5A) : 16'h0);
  end

  always @(negedge clk) begin : mon
    ev_t e;
    if (mon_on) begin
      if (mem_en && !mem_wr) begin
        if (rd_q.size() == 0) chk("unexpected_read", {16'h0, mem_addr}, 32'hFFFF_FFFF);
        else begin
          e = rd_q.pop_front();
          chk("rd_addr", mem_addr, e.addr);
          chk("rd_cycle", cyc, e.cyc);
        end
      end
      if (mem_en && mem_wr) begin
        if (wr_q.size() == 0) chk("unexpected_write", {16'h0, mem_addr}, 32'hFFFF_FFFF);
        else begin
          e = wr_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
          chk("wr_cycle", cyc, e.cyc);
        end
      end
      if (fill_we) begin
        if (fill_q.size() == 0) chk("unexpected_fill", {13'h0, fill_word, fill_data}, 32'hFFFF_FFFF);
        else begin
          e = fill_q.pop_front();
          chk("fill_sel", fill_sel, e.sel);
          chk("fill_word", fill_word, e.word);
          chk("fill_data", fill_data, e.data);
          chk("fill_cycle", cyc, e.cyc);
        end
      end
      if (idone || ddone || tag_we) begin
        if (done_q.size() == 0) chk("unexpected_done", {idone, ddone, tag_we}, 32'hFFFF_FFFF);
        else begin
          e = done_q.pop_front();
          chk("done_idone", idone, e.tag && e.sel == SEL_I);
          chk("done_ddone", ddone, e.sel == SEL_D);
          chk("done_tag_we", tag_we, e.tag);
          chk("done_cycle_sb", cyc, e.cyc);
          if (e.tag) chk("fill_base", fill_base, e.addr);
        end
      end
    end
  end

  task automatic push_miss(input logic s, input logic [15:0] b, input int t,
                           input int n_rd, input int n_fill, input logic with_done);
    for (int i = 0; i < n_rd; i++) begin
      ev_t e;
      e.addr = b + 16'(2 * i);
      e.cyc  = t + 1 + i;
      rd_q.push_back(e);
    end
    for (int i = 0; i < n_fill; i++) begin
      ev_t e;
      e.data = (b + 16'(2 * i)) ^ 16'h5A5A;
      e.word = 3'(i);
      e.sel  = s;
      e.cyc  = t + LAT + 1 + i;
      fill_q.push_back(e);
    end
    if (with_done) begin
      ev_t e;
      e.sel  = s;
      e.tag  = 1'b1;
      e.addr = b;
      e.cyc  = t + 13;
      done_q.push_back(e);
    end
  endtask

  task automatic push_store(input logic [15:0] a, input logic [15:0] d, input int t);
    ev_t e;
    e.addr = a;
    e.data = d;
    e.sel  = SEL_D;
    e.tag  = 1'b0;
    e.cyc  = t;
    wr_q.push_back(e);
    done_q.push_back(e);
  endtask

  task automatic wait_done(input int exp_c);
    int got = -1;
    for (int n = 0; n < 60 && got < 0; n++) begin
      @(negedge clk);
      if (idone || ddone) got = cyc;
    end
    chk("done_cycle", got, exp_c);
  endtask

  typedef struct {
    logic        is_store;
    logic        is_d;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_base;
  } vec_t;

  vec_t tbl[6];

  task automatic run_vec(input vec_t v);
    int t0;
    @(posedge clk); #1;
    t0 = cyc;
    if (v.is_store) begin
      dstore = 1; dstore_addr = v.addr; dstore_data = v.data;
      push_store(v.addr, v.data, t0 + 1);
    end else if (v.is_d) begin
      dmiss = 1; dmiss_addr = v.addr;
      push_miss(SEL_D, v.exp_base, t0, 8, 8, 1'b1);
    end else begin
      imiss = 1; imiss_addr = v.addr;
      push_miss(SEL_I, v.exp_base, t0, 8, 8, 1'b1);
    end
    @(negedge clk);
    chk("idle_outputs", {mem_en, fill_we, tag_we, idone, ddone, busy}, 0);
    @(posedge clk); #1;
    dstore = 0; dmiss = 0; imiss = 0;
    chk("busy_after_grant", busy, 1);
    wait_done(t0 + (v.is_store ? 1 : 13));
  endtask

  initial begin
    int t0;
    tbl[0] = '{1'b0, 1'b0, 16'h0126, 16'h0000, 16'h0120};
    tbl[1] = '{1'b0, 1'b1, 16'hFFFA, 16'h0000, 16'hFFF0};
    tbl[2] = '{1'b1, 1'b1, 16'h3002, 16'hBEEF, 16'h0000};
    tbl[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    tbl[4] = '{1'b0, 1'b1, 16'h7FFF, 16'h0000, 16'h7FF0};
    tbl[5] = '{1'b0, 1'b0, 16'hABCD, 16'h0000, 16'hABC0};

    // Reset with competing requests and stray data present.
    imiss = 1; imiss_addr = 16'h0126; stray_v = 1; stray_d = 16'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {mem_en, mem_wr, fill_we, fill_sel, fill_word, tag_we, idone, ddone, busy}, 0);
    chk("reset_data", {mem_addr, mem_wdata}, 0);
    chk("reset_fill", {fill_data, fill_base}, 0);
    @(posedge clk); #1;
    rst = 0; imiss = 0; stray_v = 0; mon_on = 1;

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Simultaneous I and D miss; I held until its grant.
    @(posedge clk); #1;
    t0 = cyc;
    imiss = 1; imiss_addr = 16'h0040; dmiss = 1; dmiss_addr = 16'h2008;
    push_miss(SEL_D, 16'h2000, t0, 8, 8, 1'b1);
    push_miss(SEL_I, 16'h0040, t0 + 14, 8, 8, 1'b1);
    @(posedge clk); #1;
    dmiss = 0;
    repeat (14) @(posedge clk);
    #1;
    imiss = 0;
    wait_done(t0 + 27);

    // Store raised mid-fill waits for the I fill to finish.
    @(posedge clk); #1;
    t0 = cyc;
    imiss = 1; imiss_addr = 16'h0500;
    push_miss(SEL_I, 16'h0500, t0, 8, 8, 1'b1);
    push_store(16'h3002, 16'hBEEF, t0 + 15);
    @(posedge clk); #1;
    imiss = 0;
    repeat (2) @(posedge clk);
    #1;
    dstore = 1; dstore_addr = 16'h3002; dstore_data = 16'hBEEF;
    repeat (12) @(posedge clk);
    #1;
    dstore = 0;
    wait_done(t0 + 15);

    // Reset abort at T+7 of a D fill.
    @(posedge clk); #1;
    t0 = cyc;
    dmiss = 1; dmiss_addr = 16'h4444;
    push_miss(SEL_D, 16'h4440, t0, 7, 3, 1'b0);
    @(posedge clk); #1;
    dmiss = 0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int k = 8; k <= 12; k++) begin
      stray_v = (k == 12);
      stray_d = 16'h1234;
      @(negedge clk);
      chk("abort_fill_we", fill_we, 0);
      chk("abort_done", {idone, ddone, tag_we}, 0);
      if (k == 8) chk("abort_outputs", {mem_en, mem_wr, busy, fill_word}, 0);
      @(posedge clk); #1;
    end
    stray_v = 0;
    chk("abort_rd_q", rd_q.size(), 0);
    chk("abort_fill_q", fill_q.size(), 0);

    // Stray return while idle, then a fresh fill must start at word 0.
    stray_v = 1; stray_d = 16'h1234;
    @(negedge clk);
    chk("stray_fill_we", fill_we, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stray_fill_we2", fill_we, 0);
    @(posedge clk); #1;
    stray_v = 0;
    run_vec(tbl[3]);

    repeat (8) @(posedge clk);
    chk("end_rd_q", rd_q.size(), 0);
    chk("end_wr_q", wr_q.size(), 0);
    chk("end_fill_q", fill_q.size(), 0);
    chk("end_done_q", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
